// File: rtl/uart_rx_if.sv
// Byte-side bus of the UART receiver: serial line in, received byte,
// completion strobe and framing status out.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_error;

    // Receiver side: samples the line, drives the byte and status.
    modport master (
        input  rx,
        output dout,
        output rx_done_tick,
        output frame_error
    );

    // Line driver / byte consumer side.
    modport slave (
        output rx,
        input  dout,
        input  rx_done_tick,
        input  frame_error
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deframer for one start bit, DBIT data bits
// (LSB first) and a stop bit spanning SB_TICK oversample ticks.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163
) (
    input  logic      clock,
    input  logic      reset,
    uart_rx_if.master bus
);
    localparam int DIV_W = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int S_MAX = (SB_TICK - 1 > 15) ? (SB_TICK - 1) : 15;
    localparam int S_W   = $clog2(S_MAX + 1);
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [DIV_W-1:0] div;
    logic             s_tick;
    logic             rx_meta;
    logic             rx_sync;
    logic [1:0]       state;
    logic [S_W-1:0]   s;
    logic [N_W-1:0]   n;
    logic [DBIT-1:0]  b;
    logic [DBIT-1:0]  b_shift;
    logic [DBIT-1:0]  dout_q;
    logic             done_q;
    logic             ferr_q;

    assign s_tick  = (div == DIV_W'(DVSR - 1));
    // New bit enters at the MSB so the first (LSB) bit ends up in b[0].
    assign b_shift = (b >> 1) | ({{(DBIT-1){1'b0}}, rx_sync} << (DBIT - 1));

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_error  = ferr_q;

    // Free-running oversample tick divider.
    always_ff @(posedge clock) begin
        if (!reset) begin
            div <= '0;
        end else if (s_tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
        end
    end

    // Deframing FSM with registered byte, strobe and framing status.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            b      <= '0;
            dout_q <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Edge detection is not tick-gated, so a start bit right
                    // after a stop sample is caught on this very clock.
                    if (!rx_sync) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_W'(7)) begin
                            if (!rx_sync) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + S_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_W'(15)) begin
                            s <= '0;
                            b <= b_shift;
                            if (n == N_W'(DBIT - 1)) begin
                                state <= STOP;
                            end else begin
                                n <= n + N_W'(1);
                            end
                        end else begin
                            s <= s + S_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == S_W'(SB_TICK - 1)) begin
                            state  <= IDLE;
                            dout_q <= b;
                            ferr_q <= ~rx_sync;
                            done_q <= 1'b1;
                        end else begin
                            s <= s + S_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DVSR=4 (64 clocks per bit), DBIT=8, SB_TICK=16.
module tb_uart_rx;
    localparam int BIT_CLKS = 64;

    logic clock;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   rd;
    int   consec;
    logic prev_tick;
    int   t_start;

    logic [7:0] q_dout[$];
    logic       q_fe[$];
    int         q_cyc[$];

    uart_rx_if #(.DBIT(8)) bus();

    uart_rx #(
        .DBIT   (8),
        .SB_TICK(16),
        .DVSR   (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle counter used for strobe latency.
    always @(posedge clock) cyc <= cyc + 1;

    // Records every strobe and flags back-to-back strobes.
    always @(negedge clock) begin
        if (bus.rx_done_tick === 1'b1) begin
            q_dout.push_back(bus.dout);
            q_fe.push_back(bus.frame_error);
            q_cyc.push_back(cyc);
            if (prev_tick) consec <= consec + 1;
        end
        prev_tick <= (bus.rx_done_tick === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int clks);
        bus.rx = lvl;
        repeat (clks) @(posedge clock);
    endtask

    // Full frame; a low stop bit returns high partway through so the
    // following idle is not mistaken for a new start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_hi);
        t_start = cyc;
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive(d[i], BIT_CLKS);
        if (stop_hi) begin
            drive(1'b1, BIT_CLKS);
        end else begin
            drive(1'b0, 48);
            drive(1'b1, 16);
        end
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic fe);
        check({tag, "_cnt"}, q_dout.size(), rd + 1);
        if (q_dout.size() > rd) begin
            check({tag, "_dout"}, {24'd0, q_dout[rd]}, {24'd0, d});
            check({tag, "_ferr"}, {31'd0, q_fe[rd]}, {31'd0, fe});
        end
        rd = q_dout.size();
    endtask

    initial begin
        int lat;
        int rd_brk;
        int c1;
        n_tests   = 0;
        n_fail    = 0;
        rd        = 0;
        consec    = 0;
        cyc       = 0;
        prev_tick = 1'b0;
        bus.rx    = 1'b1;
        reset     = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rst_dout", {24'd0, bus.dout}, 32'h0);
        check("rst_ferr", {31'd0, bus.frame_error}, 32'h0);
        check("rst_tick", {31'd0, bus.rx_done_tick}, 32'h0);
        reset = 1'b1;
        drive(1'b1, 40);

        // 0x55, clean stop; strobe near 152 ticks (608 clocks) after start edge.
        send_frame(8'h55, 1'b1);
        drive(1'b1, 16);
        if (q_dout.size() > rd) begin
            lat = q_cyc[rd] - t_start;
            check("lat_55", {31'd0, (lat >= 604 && lat <= 618)}, 32'd1);
        end
        expect_frame("f55", 8'h55, 1'b0);

        // 12-clock glitch is rejected at the mid-start check.
        drive(1'b0, 12);
        drive(1'b1, 200);
        check("glitch_cnt", q_dout.size(), rd);
        check("glitch_idle", {30'd0, dut.state}, 32'd0);
        send_frame(8'h3C, 1'b1);
        drive(1'b1, 32);
        expect_frame("f3c", 8'h3C, 1'b0);

        // Low stop bit then a clean frame clears the error.
        send_frame(8'hA3, 1'b0);
        drive(1'b1, 128);
        expect_frame("fa3", 8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        drive(1'b1, 32);
        expect_frame("f0f", 8'h0F, 1'b0);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive(1'b1, 32);
        check("b2b_cnt", q_dout.size(), rd + 2);
        if (q_dout.size() >= rd + 2) begin
            check("b2b0_dout", {24'd0, q_dout[rd]}, 32'h00);
            check("b2b0_ferr", {31'd0, q_fe[rd]}, 32'h0);
            check("b2b1_dout", {24'd0, q_dout[rd+1]}, 32'hFF);
            check("b2b1_ferr", {31'd0, q_fe[rd+1]}, 32'h0);
        end
        rd = q_dout.size();

        // Reset in the middle of data bit 4 of 0x96 (bit 4 = 1).
        drive(1'b0, BIT_CLKS);
        drive(1'b0, BIT_CLKS);
        drive(1'b1, BIT_CLKS);
        drive(1'b1, BIT_CLKS);
        drive(1'b0, BIT_CLKS);
        drive(1'b1, 32);
        reset = 1'b0;
        @(posedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_dout", {24'd0, bus.dout}, 32'h0);
        check("mid_rst_ferr", {31'd0, bus.frame_error}, 32'h0);
        drive(1'b1, 12 * BIT_CLKS);
        check("mid_rst_cnt", q_dout.size(), rd);
        send_frame(8'h96, 1'b1);
        drive(1'b1, 32);
        expect_frame("f96", 8'h96, 1'b0);

        // Break: 20 bit times low.
        rd_brk = q_dout.size();
        drive(1'b0, 20 * BIT_CLKS);
        check("brk_any", {31'd0, (q_dout.size() > rd_brk)}, 32'd1);
        if (q_dout.size() > rd_brk) begin
            check("brk_dout", {24'd0, q_dout[rd_brk]}, 32'h00);
            check("brk_ferr", {31'd0, q_fe[rd_brk]}, 32'h1);
        end
        drive(1'b1, 12 * BIT_CLKS);
        c1 = q_dout.size();
        drive(1'b1, 12 * BIT_CLKS);
        check("brk_quiet", q_dout.size(), c1);
        check("brk_idle", {30'd0, dut.state}, 32'd0);

        check("no_consec", consec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
